lookup3_stream: RTL and testbench

Streaming, parametrised Jenkins lookup3 (hashlittle) engine for the memcache key path. Keys up to 255 bytes arrive as 12-byte beats over a valid/ready handshake. The engine runs the mix rounds iteratively with a configurable number of mix steps per cycle and returns the 32-bit hash over a second valid/ready handshake. It replaces the fixed-length, fixed-depth pipelined hasher. Area is traded for throughput through `STEPS_PER_CYCLE`.

---
 rtl/lookup3_stream.sv | 211 +++++++++++++++++++++
 tb/tb_lookup3_stream.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lookup3_stream.sv
// Streaming Jenkins lookup3 (hashlittle) engine: 12-byte key beats in, 32-bit hash out.
// STEPS_PER_CYCLE mix/final lines are chained combinationally in each clock.
module lookup3_stream #(
  parameter int          STEPS_PER_CYCLE = 1,
  parameter logic [31:0] INITVAL         = 32'h0,
  parameter int          MAX_KEY_BYTES   = 250
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  key_length,
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [31:0] hashkey,
  output logic        hash_err,
  output logic        hash_valid,
  input  logic        hash_ready
);

  localparam int         S       = STEPS_PER_CYCLE;
  localparam logic [7:0] MAX_LEN = 8'(MAX_KEY_BYTES);
  localparam logic [3:0] S_W     = 4'(S);

  if (!(S == 1 || S == 2 || S == 3 || S == 6) || MAX_KEY_BYTES < 0 || MAX_KEY_BYTES > 255) begin : g_bad_param
    $fatal(1, "lookup3_stream: STEPS_PER_CYCLE must be 1, 2, 3 or 6 and MAX_KEY_BYTES 0..255");
  end

  typedef enum logic [2:0] {IDLE, LOAD, MIX, FINAL, DONE} state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [95:0] mix_line(input logic [3:0] idx, input logic [95:0] abc);
    logic [31:0] a, b, c;
    {a, b, c} = abc;
    case (idx)
      4'd0: begin a = a - c; a = a ^ rotl(c, 4);  c = c + b; end
      4'd1: begin b = b - a; b = b ^ rotl(a, 6);  a = a + c; end
      4'd2: begin c = c - b; c = c ^ rotl(b, 8);  b = b + a; end
      4'd3: begin a = a - c; a = a ^ rotl(c, 16); c = c + b; end
      4'd4: begin b = b - a; b = b ^ rotl(a, 19); a = a + c; end
      4'd5: begin c = c - b; c = c ^ rotl(b, 4);  b = b + a; end
      default: ;
    endcase
    return {a, b, c};
  endfunction

  // Indices past the seventh line pass through, so the last FINAL cycle may be partial.
  function automatic logic [95:0] final_line(input logic [3:0] idx, input logic [95:0] abc);
    logic [31:0] a, b, c;
    {a, b, c} = abc;
    case (idx)
      4'd0: begin c = c ^ b; c = c - rotl(b, 14); end
      4'd1: begin a = a ^ c; a = a - rotl(c, 11); end
      4'd2: begin b = b ^ a; b = b - rotl(a, 25); end
      4'd3: begin c = c ^ b; c = c - rotl(b, 16); end
      4'd4: begin a = a ^ c; a = a - rotl(c, 4);  end
      4'd5: begin b = b ^ a; b = b - rotl(a, 14); end
      4'd6: begin c = c ^ b; c = c - rotl(b, 24); end
      default: ;
    endcase
    return {a, b, c};
  endfunction

  state_t      state_reg;
  logic [31:0] a_reg, b_reg, c_reg;
  logic [7:0]  rem_reg;
  logic [2:0]  line_reg;
  logic        err_reg;
  logic        key_ready_reg;
  logic        hash_valid_reg;
  logic        hash_err_reg;
  logic [31:0] hashkey_reg;

  // Block rule operands: the first beat works from the freshly seeded state.
  logic        first_beat;
  logic [31:0] seed;
  logic [7:0]  rem_base;
  logic [31:0] a_base, b_base, c_base;
  logic [95:0] beat_mask, beat_words;
  logic [31:0] a_blk, b_blk, c_blk;

  assign first_beat = (state_reg == IDLE);
  assign seed       = 32'hDEADBEEF + {24'd0, key_length} + INITVAL;
  assign rem_base   = first_beat ? key_length : rem_reg;
  assign a_base     = first_beat ? seed : a_reg;
  assign b_base     = first_beat ? seed : b_reg;
  assign c_base     = first_beat ? seed : c_reg;

  for (genvar gi = 0; gi < 12; gi++) begin : g_byte_mask
    assign beat_mask[gi*8 +: 8] = (rem_base > 8'(gi)) ? 8'hFF : 8'h00;
  end

  assign beat_words = {k2, k1, k0} & beat_mask;
  assign a_blk      = a_base + beat_words[31:0];
  assign b_blk      = b_base + beat_words[63:32];
  assign c_blk      = c_base + beat_words[95:64];

  // Combinational chain of S consecutive lines starting at line_reg.
  logic [95:0] chain [0:S];
  logic [3:0]  line_sum;
  logic [31:0] a_step, b_step, c_step;

  assign chain[0] = {a_reg, b_reg, c_reg};

  for (genvar gi = 0; gi < S; gi++) begin : g_step
    logic [3:0] idx;
    assign idx          = {1'b0, line_reg} + 4'(gi);
    assign chain[gi+1]  = (state_reg == MIX) ? mix_line(idx, chain[gi]) : final_line(idx, chain[gi]);
  end

  assign {a_step, b_step, c_step} = chain[S];
  assign line_sum = {1'b0, line_reg} + S_W;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      a_reg          <= 32'd0;
      b_reg          <= 32'd0;
      c_reg          <= 32'd0;
      rem_reg        <= 8'd0;
      line_reg       <= 3'd0;
      err_reg        <= 1'b0;
      key_ready_reg  <= 1'b0;
      hash_valid_reg <= 1'b0;
      hash_err_reg   <= 1'b0;
      hashkey_reg    <= 32'd0;
    end else begin
      case (state_reg)
        IDLE, LOAD: begin
          if (key_valid && key_ready_reg) begin
            a_reg         <= a_blk;
            b_reg         <= b_blk;
            c_reg         <= c_blk;
            line_reg      <= 3'd0;
            key_ready_reg <= 1'b0;
            if (first_beat) begin
              err_reg <= (key_length > MAX_LEN);
            end
            if (rem_base > 8'd12) begin
              rem_reg   <= rem_base - 8'd12;
              state_reg <= MIX;
            end else if (rem_base != 8'd0) begin
              rem_reg   <= 8'd0;
              state_reg <= FINAL;
            end else begin
              state_reg <= DONE;
            end
          end else begin
            key_ready_reg <= 1'b1;
          end
        end

        MIX: begin
          a_reg <= a_step;
          b_reg <= b_step;
          c_reg <= c_step;
          if (line_sum >= 4'd6) begin
            line_reg      <= 3'd0;
            state_reg     <= LOAD;
            key_ready_reg <= 1'b1;
          end else begin
            line_reg <= line_sum[2:0];
          end
        end

        FINAL: begin
          a_reg <= a_step;
          b_reg <= b_step;
          c_reg <= c_step;
          if (line_sum >= 4'd7) begin
            line_reg       <= 3'd0;
            state_reg      <= DONE;
            hash_valid_reg <= 1'b1;
            hashkey_reg    <= c_step;
            hash_err_reg   <= err_reg;
          end else begin
            line_reg <= line_sum[2:0];
          end
        end

        DONE: begin
          // A zero-length key enters here without a result; publish it one cycle later.
          if (!hash_valid_reg) begin
            hash_valid_reg <= 1'b1;
            hashkey_reg    <= c_reg;
            hash_err_reg   <= err_reg;
          end else if (hash_ready) begin
            hash_valid_reg <= 1'b0;
            state_reg      <= IDLE;
            key_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg     <= IDLE;
          key_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready  = key_ready_reg;
  assign hashkey    = hashkey_reg;
  assign hash_err   = hash_err_reg;
  assign hash_valid = hash_valid_reg;

endmodule

// File: tb/tb_lookup3_stream.sv
// Bench for lookup3_stream: five instances (steps 1/2/3/6, initval 0/1) checked
// against fixed vectors and a byte-level hashlittle reference model.
module tb_lookup3_stream;

  localparam int ND = 5;

  logic        clk;
  logic        rst;
  logic [7:0]  kl   [ND];
  logic [31:0] w0   [ND];
  logic [31:0] w1   [ND];
  logic [31:0] w2   [ND];
  logic        kv   [ND];
  logic        krdy [ND];
  logic        hr   [ND];
  logic        hv   [ND];
  logic        herr [ND];
  logic [31:0] hk   [ND];

  int cyc;
  int tests;
  int fails;
  byte unsigned key_buf [0:271];

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int          SP = (gi == 1) ? 2 : (gi == 2) ? 3 : (gi == 3) ? 6 : 1;
    localparam logic [31:0] IV = (gi == 4) ? 32'd1 : 32'd0;
    lookup3_stream #(.STEPS_PER_CYCLE(SP), .INITVAL(IV), .MAX_KEY_BYTES(250)) u_dut (
      .CLK        (clk),
      .RST        (rst),
      .key_length (kl[gi]),
      .k0         (w0[gi]),
      .k1         (w1[gi]),
      .k2         (w2[gi]),
      .key_valid  (kv[gi]),
      .key_ready  (krdy[gi]),
      .hashkey    (hk[gi]),
      .hash_err   (herr[gi]),
      .hash_valid (hv[gi]),
      .hash_ready (hr[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sp_of(input int d);
    return (d == 1) ? 2 : (d == 2) ? 3 : (d == 3) ? 6 : 1;
  endfunction

  function automatic logic [31:0] iv_of(input int d);
    return (d == 4) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] rot(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] word_at(input int off);
    return {key_buf[off+3], key_buf[off+2], key_buf[off+1], key_buf[off]};
  endfunction

  // Reference hashlittle over key_buf[0 .. len-1], byte at a time for the tail.
  function automatic logic [31:0] ref_hash(input int len, input logic [31:0] iv);
    logic [31:0] a, b, c;
    logic [31:0] w [3];
    int off, rem;
    a = 32'hDEADBEEF + 32'(len) + iv;
    b = a;
    c = a;
    off = 0;
    rem = len;
    while (rem > 12) begin
      a += word_at(off);
      b += word_at(off + 4);
      c += word_at(off + 8);
      a -= c; a ^= rot(c, 4);  c += b;
      b -= a; b ^= rot(a, 6);  a += c;
      c -= b; c ^= rot(b, 8);  b += a;
      a -= c; a ^= rot(c, 16); c += b;
      b -= a; b ^= rot(a, 19); a += c;
      c -= b; c ^= rot(b, 4);  b += a;
      rem -= 12;
      off += 12;
    end
    if (rem == 0) return c;
    w[0] = 32'd0;
    w[1] = 32'd0;
    w[2] = 32'd0;
    for (int i = 0; i < rem; i++) begin
      w[i/4] = w[i/4] | (32'(key_buf[off+i]) << (8 * (i % 4)));
    end
    a += w[0];
    b += w[1];
    c += w[2];
    c ^= b; c -= rot(b, 14);
    a ^= c; a -= rot(c, 11);
    b ^= a; b -= rot(a, 25);
    c ^= b; c -= rot(b, 16);
    a ^= c; a -= rot(c, 4);
    b ^= a; b -= rot(a, 14);
    c ^= b; c -= rot(b, 24);
    return c;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 272; i++) key_buf[i] = 8'($urandom());
  endtask

  task automatic load_four_score();
    string s;
    s = "Four score and seven years ago";
    for (int i = 0; i < 272; i++) key_buf[i] = 8'($urandom());
    for (int i = 0; i < 36; i++) key_buf[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  // Feed key_buf as one key to instance d with key_valid held high, then take the result.
  task automatic run_key(input int d, input int len, input int hold,
                         input logic [31:0] exp_h, input logic exp_e);
    int nb, e0, waitc, s, m, f, exp_lat, lat;
    s  = sp_of(d);
    m  = 6 / s;
    f  = (7 + s - 1) / s;
    nb = (len == 0) ? 1 : (len + 11) / 12;
    exp_lat = (len == 0) ? 1 : (nb - 1) * (m + 1) + f;
    hr[d] = (hold == 0);
    kl[d] = 8'(len);
    e0 = 0;
    for (int bi = 0; bi < nb; bi++) begin
      w0[d] = word_at(bi * 12);
      w1[d] = word_at(bi * 12 + 4);
      w2[d] = word_at(bi * 12 + 8);
      kv[d] = 1'b1;
      waitc = 0;
      while (krdy[d] !== 1'b1 && waitc < 100) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 100) begin
        check1($sformatf("key_ready_timeout d%0d len%0d beat%0d", d, len, bi), 1'b0, 1'b1);
        kv[d] = 1'b0;
        hr[d] = 1'b1;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (bi == 0) e0 = cyc;
    end
    kv[d] = 1'b0;
    waitc = 0;
    while (hv[d] !== 1'b1 && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 300) begin
      check1($sformatf("hash_valid_timeout d%0d len%0d", d, len), 1'b0, 1'b1);
      hr[d] = 1'b1;
      return;
    end
    lat = cyc - e0;
    check32($sformatf("latency d%0d len%0d", d, len), 32'(lat), 32'(exp_lat));
    check32($sformatf("hashkey d%0d len%0d", d, len), hk[d], exp_h);
    check1($sformatf("hash_err d%0d len%0d", d, len), herr[d], exp_e);
    for (int i = 0; i < hold; i++) begin
      kv[d] = i[0];
      kl[d] = 8'h07;
      w0[d] = $urandom();
      @(posedge clk);
      @(negedge clk);
      check1($sformatf("hold_valid cyc%0d", i), hv[d], 1'b1);
      check32($sformatf("hold_hashkey cyc%0d", i), hk[d], exp_h);
      check1($sformatf("hold_key_ready cyc%0d", i), krdy[d], 1'b0);
    end
    kv[d] = 1'b0;
    hr[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1($sformatf("valid_drop d%0d len%0d", d, len), hv[d], 1'b0);
    check1($sformatf("ready_after_result d%0d len%0d", d, len), krdy[d], 1'b1);
  endtask

  typedef struct {
    int          d;
    int          len;
    int          msg;
    logic [31:0] exp_h;
    logic        exp_e;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int waitc;
    int len;
    int d;
    logic [31:0] exp_h;
    int edge_lens [4];

    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b1;
    for (int i = 0; i < ND; i++) begin
      kl[i] = 8'd0; w0[i] = 32'd0; w1[i] = 32'd0; w2[i] = 32'd0;
      kv[i] = 1'b0; hr[i] = 1'b1;
    end

    vecs[0] = '{d: 0, len: 0,  msg: 0, exp_h: 32'hDEADBEEF, exp_e: 1'b0};
    vecs[1] = '{d: 4, len: 0,  msg: 0, exp_h: 32'hDEADBEF0, exp_e: 1'b0};
    vecs[2] = '{d: 0, len: 30, msg: 1, exp_h: 32'h17770551, exp_e: 1'b0};
    vecs[3] = '{d: 1, len: 30, msg: 1, exp_h: 32'h17770551, exp_e: 1'b0};
    vecs[4] = '{d: 2, len: 30, msg: 1, exp_h: 32'h17770551, exp_e: 1'b0};
    vecs[5] = '{d: 3, len: 30, msg: 1, exp_h: 32'h17770551, exp_e: 1'b0};
    vecs[6] = '{d: 4, len: 30, msg: 1, exp_h: 32'hCD628161, exp_e: 1'b0};

    // Reset values while RST is held.
    repeat (3) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      check1($sformatf("reset key_ready d%0d", i), krdy[i], 1'b0);
      check1($sformatf("reset hash_valid d%0d", i), hv[i], 1'b0);
      check32($sformatf("reset hashkey d%0d", i), hk[i], 32'd0);
      check1($sformatf("reset hash_err d%0d", i), herr[i], 1'b0);
    end
    rst = 1'b0;

    // Fixed vectors: zero-length keys and the 30-byte key on every configuration.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].msg == 1) load_four_score();
      else fill_random();
      run_key(vecs[v].d, vecs[v].len, 0, vecs[v].exp_h, vecs[v].exp_e);
    end

    // Beat-boundary and out-of-range lengths.
    edge_lens[0] = 12;
    edge_lens[1] = 13;
    edge_lens[2] = 251;
    edge_lens[3] = 255;
    for (int i = 0; i < 4; i++) begin
      for (int dd = 0; dd < ND; dd++) begin
        fill_random();
        exp_h = ref_hash(edge_lens[i], iv_of(dd));
        run_key(dd, edge_lens[i], 0, exp_h, edge_lens[i] > 250);
      end
    end

    // Random keys against the reference model.
    for (int n = 0; n < 200; n++) begin
      len = $urandom_range(0, 250);
      d   = $urandom_range(0, ND - 1);
      fill_random();
      exp_h = ref_hash(len, iv_of(d));
      run_key(d, len, 0, exp_h, 1'b0);
    end

    // Result held in DONE for 10 cycles, then the next key follows straight after release.
    load_four_score();
    run_key(0, 30, 10, 32'h17770551, 1'b0);
    fill_random();
    exp_h = ref_hash(13, 32'd0);
    run_key(0, 13, 0, exp_h, 1'b0);

    // Reset in the middle of the first MIX of a 3-beat key.
    fill_random();
    kl[0] = 8'd30;
    w0[0] = word_at(0);
    w1[0] = word_at(4);
    w2[0] = word_at(8);
    kv[0] = 1'b1;
    waitc = 0;
    while (krdy[0] !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check1("mid_mix key_ready seen", krdy[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    kv[0] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check1("mid_mix reset key_ready", krdy[0], 1'b0);
    check1("mid_mix reset hash_valid", hv[0], 1'b0);
    check32("mid_mix reset hashkey", hk[0], 32'd0);
    check1("mid_mix reset hash_err", herr[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    load_four_score();
    run_key(0, 30, 0, 32'h17770551, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete, %0d failures so far", fails);
    $fatal(1, "timeout");
  end

endmodule
